// File: rtl/mult_scheduler.sv
// Round-robin front end that time-shares one iterative shift-add multiplier
// between REQS requesters, with a per-operation timeout and a held response.
module mult_scheduler #(
    parameter int N     = 8,
    parameter int REQS  = 4,
    parameter int IDW   = 2,
    parameter int SLACK = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [REQS-1:0]     req_valid,
    input  logic [REQS*N-1:0]   req_a,
    input  logic [REQS*N-1:0]   req_b,
    output logic [REQS-1:0]     req_ready,
    output logic [N-1:0]        mul_a,
    output logic [N-1:0]        mul_b,
    output logic                mul_start,
    input  logic                mul_finish,
    input  logic [2*N-1:0]      mul_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [2*N-1:0]      rsp_product,
    output logic                rsp_error,
    output logic                busy
);

    localparam int CW = $clog2(N + SLACK + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t           state, state_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   rr_idx;
    logic [IDW-1:0]   grant_id;
    logic             grant_any;
    logic [IDW-1:0]   id_q;
    logic [N-1:0]     a_q, b_q;
    logic [CW-1:0]    run_cnt;
    logic [2*N-1:0]   prod_q;
    logic             err_q;
    logic             timeout;

    // Search starts at ptr and wraps; the first asserted request wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        rr_idx    = '0;
        for (int unsigned i = 0; i < REQS; i++) begin
            rr_idx = IDW'((32'(ptr) + i) % REQS);
            if (!grant_any && req_valid[rr_idx]) begin
                grant_any = 1'b1;
                grant_id  = rr_idx;
            end
        end
    end

    // Counter lands on N+SLACK at the same edge that leaves RUN.
    assign timeout = (run_cnt == CW'(N + SLACK - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant_any) state_next = LOAD;
            LOAD: state_next = RUN;
            RUN:  if (mul_finish || timeout) state_next = RESP;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            run_cnt <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        a_q  <= req_a[grant_id*N +: N];
                        b_q  <= req_b[grant_id*N +: N];
                        id_q <= grant_id;
                        ptr  <= (grant_id == IDW'(REQS - 1)) ? '0 : grant_id + 1'b1;
                    end
                end
                LOAD: run_cnt <= '0;
                RUN: begin
                    run_cnt <= run_cnt + 1'b1;
                    if (mul_finish) begin
                        prod_q <= mul_out;
                        err_q  <= 1'b0;
                    end else if (timeout) begin
                        prod_q <= '0;
                        err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Grant is combinational, so it is also gated by reset to read zero while held.
    assign req_ready   = (state == IDLE && reset && grant_any) ? (REQS'(1) << grant_id) : '0;
    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign mul_start   = (state == RUN);
    assign rsp_valid   = (state == RESP);
    assign rsp_id      = id_q;
    assign rsp_product = prod_q;
    assign rsp_error   = err_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed and randomized bench for mult_scheduler with a behavioural multiplier
// and a queue-free round-robin reference kept as plain arrays.
module tb_mult_scheduler;

    localparam int N     = 8;
    localparam int REQS  = 4;
    localparam int IDW   = 2;
    localparam int SLACK = 4;
    localparam int W2    = 2 * N;

    logic                clock;
    logic                reset;
    logic [REQS-1:0]     req_valid;
    logic [REQS*N-1:0]   req_a;
    logic [REQS*N-1:0]   req_b;
    logic [REQS-1:0]     req_ready;
    logic [N-1:0]        mul_a;
    logic [N-1:0]        mul_b;
    logic                mul_start;
    logic                mul_finish;
    logic [W2-1:0]       mul_out;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [W2-1:0]       rsp_product;
    logic                rsp_error;
    logic                busy;

    mult_scheduler #(.N(N), .REQS(REQS), .IDW(IDW), .SLACK(SLACK)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_finish(mul_finish), .mul_out(mul_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .rsp_error(rsp_error), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Multiplier stand-in: loads while start=0, raises finish after N iterating edges.
    logic [N-1:0] ma, mb;
    int           mcnt;
    bit           tie_low;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcnt <= 0; mul_finish <= 1'b0; mul_out <= '0; ma <= '0; mb <= '0;
        end else if (!mul_start) begin
            ma <= mul_a; mb <= mul_b; mcnt <= 0; mul_finish <= 1'b0;
        end else if (mcnt < N) begin
            mcnt <= mcnt + 1;
            if (mcnt == N - 1 && !tie_low) begin
                mul_finish <= 1'b1;
                mul_out    <= W2'(ma) * W2'(mb);
            end
        end
    end

    int              vectors;
    int              miscompares;
    int              ptr_m;
    logic [REQS-1:0] vmask;
    logic [N-1:0]    a_m [REQS];
    logic [N-1:0]    b_m [REQS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick();
        for (int i = 0; i < REQS; i++)
            if (vmask[(ptr_m + i) % REQS]) return (ptr_m + i) % REQS;
        return -1;
    endfunction

    task automatic apply();
        for (int k = 0; k < REQS; k++) begin
            req_a[k*N +: N] = a_m[k];
            req_b[k*N +: N] = b_m[k];
        end
        req_valid = vmask;
    endtask

    task automatic new_ops(input int k);
        a_m[k] = N'($urandom_range(0, 255));
        b_m[k] = N'($urandom_range(0, 255));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_start"}, mul_start, 0);
        chk({tag, "_mula"}, mul_a, 0);
        chk({tag, "_mulb"}, mul_b, 0);
        chk({tag, "_rvalid"}, rsp_valid, 0);
        chk({tag, "_rid"}, rsp_id, 0);
        chk({tag, "_rprod"}, rsp_product, 0);
        chk({tag, "_rerr"}, rsp_error, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // One full transaction from the IDLE grant to the response being consumed.
    task automatic serve(input int stall, input bit to, input bit keep, output int k);
        int            cyc;
        logic [N-1:0]  ea, eb;
        logic [W2-1:0] ep;
        k = rr_pick();
        apply(); #1;
        chk("idle_busy", busy, 0);
        chk("grant", req_ready, (k < 0) ? 64'd0 : (64'd1 << k));
        if (k < 0) return;
        ea = a_m[k]; eb = b_m[k];
        ep = to ? '0 : W2'(ea) * W2'(eb);
        @(posedge clock); #1;
        ptr_m = (k + 1) % REQS;
        if (keep) new_ops(k); else vmask[k] = 1'b0;
        apply(); #1;
        chk("load_start", mul_start, 0);
        chk("load_a", mul_a, ea);
        chk("load_b", mul_b, eb);
        chk("load_ready", req_ready, 0);
        cyc = 0;
        do begin
            @(posedge clock); #1;
            cyc++;
            if (cyc == 1) chk("run_start", mul_start, 1);
        end while (!rsp_valid && cyc < 40);
        chk("latency", cyc, to ? N + SLACK + 1 : N + 2);
        chk("rsp_id", rsp_id, k);
        chk("rsp_product", rsp_product, ep);
        chk("rsp_error", rsp_error, to);
        chk("resp_start", mul_start, 0);
        chk("resp_ready", req_ready, 0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clock); #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_id", rsp_id, k);
            chk("hold_product", rsp_product, ep);
            chk("hold_error", rsp_error, to);
            chk("hold_no_grant", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        chk("resp_done", rsp_valid, 0);
        chk("back_idle", busy, 0);
    endtask

    initial begin
        int k;
        vectors = 0; miscompares = 0; ptr_m = 0; tie_low = 1'b0;
        rsp_ready = 1'b0; reset = 1'b0;
        for (int i = 0; i < REQS; i++) new_ops(i);
        vmask = '1;
        apply();
        repeat (2) @(negedge clock);
        check_zero("reset");
        reset = 1'b1;
        vmask = '0;
        apply();
        @(posedge clock); #1;
        chk("idle_no_req", req_ready, 0);

        // single request from requester 2
        vmask[2] = 1'b1; a_m[2] = 8'd13; b_m[2] = 8'd11;
        serve(0, 0, 0, k);
        chk("single_k", k, 2);

        // contention after a fresh reset: grant order 0,1,2,3,0
        reset = 1'b0; @(posedge clock); #1; reset = 1'b1; ptr_m = 0;
        for (int i = 0; i < REQS; i++) new_ops(i);
        vmask = '1;
        for (int i = 0; i < 5; i++) begin
            serve(0, 0, 1, k);
            chk("order", k, i % REQS);
        end

        // operand boundaries
        vmask = '0;
        vmask[1] = 1'b1; a_m[1] = 8'd255; b_m[1] = 8'd255;
        serve(0, 0, 0, k);
        vmask[3] = 1'b1; a_m[3] = 8'd0; b_m[3] = 8'd200;
        serve(0, 0, 0, k);

        // timeout, then a normal completion
        vmask[0] = 1'b1; new_ops(0); tie_low = 1'b1;
        serve(0, 1, 0, k);
        tie_low = 1'b0;
        vmask[0] = 1'b1; new_ops(0);
        serve(0, 0, 0, k);

        // backpressure with a second requester waiting
        vmask[1] = 1'b1; new_ops(1);
        vmask[2] = 1'b1; new_ops(2);
        serve(5, 0, 0, k);
        serve(0, 0, 0, k);

        // randomized traffic; waiting requesters keep their operands
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < REQS; i++)
                if (!vmask[i] && $urandom_range(0, 1) == 1) begin
                    vmask[i] = 1'b1; new_ops(i);
                end
            if (vmask == '0) begin
                k = int'($urandom_range(0, REQS - 1));
                vmask[k] = 1'b1; new_ops(k);
            end
            serve(int'($urandom_range(0, 3)), 0, bit'($urandom_range(0, 1)), k);
        end

        // reset in the middle of RUN discards the operation
        vmask = '0;
        vmask[2] = 1'b1; new_ops(2);
        apply(); #1;
        chk("mid_grant", req_ready, 4'b0100);
        @(posedge clock); #1;
        repeat (4) @(posedge clock);
        #1;
        chk("mid_running", mul_start, 1);
        reset = 1'b0; #1;
        check_zero("mid_reset");
        vmask[0] = 1'b1; new_ops(0);
        apply(); #1;
        chk("mid_reset_ready", req_ready, 0);
        @(posedge clock); #1;
        chk("mid_reset_no_rsp", rsp_valid, 0);
        reset = 1'b1; ptr_m = 0;
        serve(0, 0, 0, k);
        chk("post_reset_first", k, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
